// File: rtl/ifid_hazard_ctrl.sv
// Front-end pipeline control: PC / IF-ID enables, ID-EX bubble, back-end freeze and HALT drain.
// Control outputs are combinational from state and inputs; state and counters are registered.
module ifid_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       id_rs,
   input  logic             id_rs_valid,
   input  logic [2:0]       id_rt,
   input  logic             id_rt_valid,
   input  logic             ex_memread,
   input  logic [2:0]       ex_rd,
   input  logic             br_taken,
   input  logic             imem_stall,
   input  logic             dmem_stall,
   input  logic             id_halt,
   output logic             pc_write,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_freeze,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

   localparam logic [2:0]       DrainInit = 3'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CntMax    = '1;

   state_e           state_q, state_d;
   logic [2:0]       drain_q, drain_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             stall_inc, flush_inc;
   logic             load_use;

   assign load_use = ex_memread & ((id_rs_valid & (id_rs == ex_rd)) |
                                   (id_rt_valid & (id_rt == ex_rd)));

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      pc_write    = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      halted      = 1'b0;

      unique case (state_q)
         StRun: begin
            if (dmem_stall) begin
               pipe_freeze = 1'b1;
               stall_inc   = 1'b1;
            end else if (br_taken) begin
               // A HALT in ID is on the wrong path and is squashed with the flush.
               pc_write    = 1'b1;
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               flush_inc   = 1'b1;
            end else if (load_use) begin
               idex_bubble = 1'b1;
               stall_inc   = 1'b1;
            end else if (id_halt) begin
               ifid_en    = 1'b1;
               ifid_flush = 1'b1;
               state_d    = StDrain;
               drain_d    = DrainInit;
            end else if (imem_stall) begin
               ifid_en    = 1'b1;
               ifid_flush = 1'b1;
               stall_inc  = 1'b1;
            end else begin
               pc_write = 1'b1;
               ifid_en  = 1'b1;
            end
         end
         StDrain: begin
            ifid_flush = 1'b1;
            if (dmem_stall) begin
               pipe_freeze = 1'b1;
               stall_inc   = 1'b1;
            end else begin
               ifid_en = 1'b1;
               drain_d = drain_q - 3'd1;
               if (drain_q == 3'd1) state_d = StHalt;
            end
         end
         StHalt: begin
            idex_bubble = 1'b1;
            halted      = 1'b1;
         end
         default: begin
            state_d = StRun;
         end
      endcase

      stall_d = (stall_inc && (stall_q != CntMax)) ? stall_q + CNT_W'(1) : stall_q;
      flush_d = (flush_inc && (flush_q != CntMax)) ? flush_q + CNT_W'(1) : flush_q;

      // Reset holds the front end in a safe NOP-injecting configuration.
      if (rst) begin
         pc_write    = 1'b0;
         ifid_en     = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         pipe_freeze = 1'b0;
         halted      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         drain_q <= 3'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Scoreboard bench for ifid_hazard_ctrl: per-cycle stimulus with expected outputs queued
// at drive time and popped for comparison mid-cycle.
module tb_ifid_hazard_ctrl;

   localparam int unsigned CW = 4;

   // Output vector order: {pc_write, ifid_en, ifid_flush, idex_bubble, pipe_freeze, halted}
   localparam logic [5:0] CtlRun  = 6'b110000;
   localparam logic [5:0] CtlDmem = 6'b000010;
   localparam logic [5:0] CtlBr   = 6'b111100;
   localparam logic [5:0] CtlLu   = 6'b000100;
   localparam logic [5:0] CtlFill = 6'b011000;
   localparam logic [5:0] CtlDrnF = 6'b001010;
   localparam logic [5:0] CtlHalt = 6'b000101;
   localparam logic [5:0] CtlRst  = 6'b011100;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    id_rs, id_rt, ex_rd;
   logic          id_rs_valid, id_rt_valid, ex_memread;
   logic          br_taken, imem_stall, dmem_stall, id_halt;
   logic          pc_write, ifid_en, ifid_flush, idex_bubble, pipe_freeze, halted;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [5:0]    outs;

   assign outs = {pc_write, ifid_en, ifid_flush, idex_bubble, pipe_freeze, halted};

   always #5 clk = ~clk;

   ifid_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_rt(id_rt), .id_rt_valid(id_rt_valid),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .br_taken(br_taken),
      .imem_stall(imem_stall), .dmem_stall(dmem_stall), .id_halt(id_halt),
      .pc_write(pc_write), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct packed {
      logic       r, dm, br, hl, im, mr;
      logic [2:0] rd, rs;
      logic       rsv;
      logic [2:0] rt;
      logic       rtv;
   } stim_t;

   typedef struct packed {
      logic [5:0]    ctl;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic stim_t mk(input logic r = 1'b0, input logic dm = 1'b0,
                                input logic br = 1'b0, input logic hl = 1'b0,
                                input logic im = 1'b0, input logic mr = 1'b0,
                                input logic [2:0] rd = 3'd0, input logic [2:0] rs = 3'd0,
                                input logic rsv = 1'b0, input logic [2:0] rt = 3'd0,
                                input logic rtv = 1'b0);
      stim_t s;
      s.r = r; s.dm = dm; s.br = br; s.hl = hl; s.im = im; s.mr = mr;
      s.rd = rd; s.rs = rs; s.rsv = rsv; s.rt = rt; s.rtv = rtv;
      return s;
   endfunction

   function automatic exp_t ev(input logic [5:0] c, input int unsigned s, input int unsigned f);
      exp_t e;
      e.ctl = c;
      e.sc  = CW'(s);
      e.fc  = CW'(f);
      return e;
   endfunction

   // Drive one cycle of stimulus and queue what the DUT must show during it.
   task automatic drive_push(input stim_t s, input exp_t e);
      rst = s.r; dmem_stall = s.dm; br_taken = s.br; id_halt = s.hl; imem_stall = s.im;
      ex_memread = s.mr; ex_rd = s.rd; id_rs = s.rs; id_rs_valid = s.rsv;
      id_rt = s.rt; id_rt_valid = s.rtv;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      drive_push(mk(.r(1'b1)), ev(CtlRst, 0, 0));
      @(posedge clk); #1;
      void'(sb.pop_front());
   endtask

   task automatic test_reset();
      exp_t e;
      do_reset();
      drive_push(mk(.r(1'b1), .br(1'b1), .dm(1'b1), .hl(1'b1)), ev(CtlRst, 0, 0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs !== e.ctl) begin
         errors++; $display("FAIL reset ctl got %b want %b", outs, e.ctl);
      end
      checks++;
      if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
         errors++; $display("FAIL reset cnt got %0d/%0d want %0d/%0d",
                            stall_cnt, flush_cnt, e.sc, e.fc);
      end
      @(posedge clk); #1;
   endtask

   // Each scenario task fills these tables, then runs them through the scoreboard.
   task automatic run_table(input string name, input stim_t st[$], input exp_t ex[$]);
      exp_t e;
      for (int i = 0; i < st.size(); i++) begin
         drive_push(st[i], ex[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (outs !== e.ctl) begin
            errors++; $display("FAIL %s[%0d] ctl got %b want %b", name, i, outs, e.ctl);
         end
         checks++;
         if (stall_cnt !== e.sc) begin
            errors++; $display("FAIL %s[%0d] stall_cnt got %0d want %0d", name, i, stall_cnt, e.sc);
         end
         checks++;
         if (flush_cnt !== e.fc) begin
            errors++; $display("FAIL %s[%0d] flush_cnt got %0d want %0d", name, i, flush_cnt, e.fc);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t st[$];
      exp_t  ex[$];
      do_reset();
      st.push_back(mk(.mr(1'b1), .rd(3'd3), .rs(3'd3), .rsv(1'b1))); ex.push_back(ev(CtlLu, 0, 0));
      st.push_back(mk());                                             ex.push_back(ev(CtlRun, 1, 0));
      st.push_back(mk(.mr(1'b1), .rd(3'd3), .rs(3'd3)));              ex.push_back(ev(CtlRun, 1, 0));
      st.push_back(mk(.mr(1'b1), .rd(3'd5), .rt(3'd5), .rtv(1'b1))); ex.push_back(ev(CtlLu, 1, 0));
      st.push_back(mk(.mr(1'b1), .rd(3'd5), .rt(3'd4), .rtv(1'b1))); ex.push_back(ev(CtlRun, 2, 0));
      st.push_back(mk(.rd(3'd3), .rs(3'd3), .rsv(1'b1)));             ex.push_back(ev(CtlRun, 2, 0));
      st.push_back(mk());                                             ex.push_back(ev(CtlRun, 2, 0));
      run_table("load_use", st, ex);
   endtask

   task automatic test_priority();
      stim_t st[$];
      exp_t  ex[$];
      do_reset();
      st.push_back(mk(.br(1'b1), .mr(1'b1), .rd(3'd3), .rs(3'd3), .rsv(1'b1)));
      ex.push_back(ev(CtlBr, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 0, 1));
      st.push_back(mk(.dm(1'b1), .br(1'b1), .mr(1'b1), .rd(3'd3), .rs(3'd3), .rsv(1'b1)));
      ex.push_back(ev(CtlDmem, 0, 1));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 1, 1));
      st.push_back(mk(.im(1'b1)));                  ex.push_back(ev(CtlFill, 1, 1));
      st.push_back(mk(.im(1'b1), .mr(1'b1), .rd(3'd2), .rs(3'd2), .rsv(1'b1)));
      ex.push_back(ev(CtlLu, 2, 1));
      st.push_back(mk(.br(1'b1), .im(1'b1)));       ex.push_back(ev(CtlBr, 3, 1));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 3, 2));
      run_table("priority", st, ex);
   endtask

   task automatic test_halt();
      stim_t st[$];
      exp_t  ex[$];
      do_reset();
      st.push_back(mk(.hl(1'b1)));                  ex.push_back(ev(CtlFill, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlFill, 0, 0));
      st.push_back(mk(.hl(1'b1), .br(1'b1), .im(1'b1), .mr(1'b1), .rd(3'd1), .rs(3'd1),
                      .rsv(1'b1)));                 ex.push_back(ev(CtlFill, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlFill, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlHalt, 0, 0));
      st.push_back(mk(.br(1'b1), .im(1'b1)));       ex.push_back(ev(CtlHalt, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlHalt, 0, 0));
      st.push_back(mk(.r(1'b1)));                   ex.push_back(ev(CtlRst, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 0, 0));
      run_table("halt", st, ex);
   endtask

   task automatic test_halt_dmem();
      stim_t st[$];
      exp_t  ex[$];
      do_reset();
      st.push_back(mk(.hl(1'b1)));                  ex.push_back(ev(CtlFill, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlFill, 0, 0));
      st.push_back(mk(.dm(1'b1)));                  ex.push_back(ev(CtlDrnF, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlFill, 1, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlFill, 1, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlHalt, 1, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlHalt, 1, 0));
      run_table("halt_dmem", st, ex);
   endtask

   task automatic test_squash();
      stim_t st[$];
      exp_t  ex[$];
      do_reset();
      st.push_back(mk(.hl(1'b1), .br(1'b1)));       ex.push_back(ev(CtlBr, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 0, 1));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 0, 1));
      st.push_back(mk(.hl(1'b1)));                  ex.push_back(ev(CtlFill, 0, 1));
      st.push_back(mk(.dm(1'b1)));                  ex.push_back(ev(CtlDrnF, 0, 1));
      st.push_back(mk(.r(1'b1)));                   ex.push_back(ev(CtlRst, 1, 1));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 0, 0));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 0, 0));
      run_table("squash", st, ex);
   endtask

   task automatic test_saturation();
      stim_t st[$];
      exp_t  ex[$];
      do_reset();
      for (int i = 0; i < 20; i++) begin
         st.push_back(mk(.im(1'b1)));
         ex.push_back(ev(CtlFill, (i > 15) ? 15 : i, 0));
      end
      for (int i = 0; i < 18; i++) begin
         st.push_back(mk(.br(1'b1)));
         ex.push_back(ev(CtlBr, 15, (i > 15) ? 15 : i));
      end
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 15, 15));
      st.push_back(mk(.r(1'b1), .im(1'b1)));        ex.push_back(ev(CtlRst, 15, 15));
      st.push_back(mk());                           ex.push_back(ev(CtlRun, 0, 0));
      run_table("saturation", st, ex);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_priority();
      test_halt();
      test_halt_dmem();
      test_squash();
      test_saturation();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
